// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and load/store requests onto the single-ported ram,
// turning its pulse handshake into req/ack. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ack,
    output logic        i_exc,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_exc,
    output logic [31:0] m_r_addr,
    output logic [31:0] m_w_addr,
    output logic [31:0] m_w_line,
    output logic        m_read,
    output logic        m_write,
    input  logic [31:0] m_r_line,
    input  logic        m_rrdy,
    input  logic        m_wrdy,
    input  logic        m_exc,
    output logic        busy,
    output logic        owner
);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] { IDLE, BUS, RESP } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       grant_d;
    logic       qualified;
    logic       rsp_ok;
    logic       rsp_fail;

`ifdef MEM_ARB_RR_EN
    logic rr_prio_d;  // 1: data port wins the next simultaneous request

    always_comb begin
        grant_d = d_req;
        if (i_req && d_req) grant_d = rr_prio_d;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_prio_d <= 1'b0;
        else if (state == IDLE && (i_req || d_req)) rr_prio_d <= !grant_d;
    end
`else
    always_comb grant_d = d_req;
`endif

    // The ram's exc is sticky from the previous op, so the first BUS cycle is never trusted.
    always_comb begin
        qualified = (wait_cnt != '0);
        rsp_ok    = qualified && (m_write ? m_wrdy : m_rrdy);
        rsp_fail  = qualified && !rsp_ok && (m_exc || wait_cnt == TIMEOUT_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            m_r_addr <= '0;
            m_w_addr <= '0;
            m_w_line <= '0;
            m_read   <= 1'b0;
            m_write  <= 1'b0;
            i_data   <= '0;
            d_rdata  <= '0;
            i_ack    <= 1'b0;
            i_exc    <= 1'b0;
            d_ack    <= 1'b0;
            d_exc    <= 1'b0;
            busy     <= 1'b0;
            owner    <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            i_exc <= 1'b0;
            d_ack <= 1'b0;
            d_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state    <= BUS;
                        busy     <= 1'b1;
                        owner    <= grant_d;
                        wait_cnt <= '0;
                        if (grant_d && d_we) begin
                            m_w_addr <= d_addr;
                            m_w_line <= d_wdata;
                            m_write  <= 1'b1;
                        end else begin
                            m_r_addr <= grant_d ? d_addr : i_addr;
                            m_read   <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (rsp_ok || rsp_fail) begin
                        state   <= RESP;
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                        if (owner) begin
                            d_ack <= 1'b1;
                            d_exc <= rsp_fail;
                            if (m_read) d_rdata <= rsp_ok ? m_r_line : '0;
                        end else begin
                            i_ack  <= 1'b1;
                            i_exc  <= rsp_fail;
                            i_data <= rsp_ok ? m_r_line : '0;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed checks from the test plan, then randomized traffic
// against a transaction-level model of arbitration order, memory contents and exceptions.
module tb_mem_arbiter;
    localparam int unsigned TO    = 4;
    localparam int unsigned DEPTH = 1024;
`ifdef MEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        i_req   = 1'b0;
    logic [31:0] i_addr  = '0;
    logic        d_req   = 1'b0;
    logic        d_we    = 1'b0;
    logic [31:0] d_addr  = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] i_data, d_rdata, m_r_addr, m_w_addr, m_w_line;
    logic        i_ack, i_exc, d_ack, d_exc, m_read, m_write, busy, owner;

    logic [31:0] ram_mem [DEPTH];
    logic [31:0] ram_line = '0;
    logic        ram_rrdy = 1'b0, ram_wrdy = 1'b0, ram_exc = 1'b0;
    logic        rd_q = 1'b0, wr_q = 1'b0, mute = 1'b0;

    logic [31:0] ref_mem [DEPTH];
    int total = 0, bad = 0, cyc = 0, ack_cyc = 0, t0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ack(i_ack), .i_exc(i_exc),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_exc(d_exc),
        .m_r_addr(m_r_addr), .m_w_addr(m_w_addr), .m_w_line(m_w_line),
        .m_read(m_read), .m_write(m_write),
        .m_r_line(ram_line), .m_rrdy(ram_rrdy & ~mute), .m_wrdy(ram_wrdy & ~mute),
        .m_exc(ram_exc & ~mute),
        .busy(busy), .owner(owner)
    );

    function automatic logic [31:0] init_word(input int unsigned a);
        return (a == 5) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B9) ^ 32'h0BAD_F00D);
    endfunction

    // ram: acts on the rising edge of a strobe, pulses rrdy/wrdy, exc sticky until the next op
    initial begin : ram_model
        for (int unsigned a = 0; a < DEPTH; a++) ram_mem[a] <= init_word(a);
        forever begin
            @(posedge clk);
            ram_rrdy <= 1'b0;
            ram_wrdy <= 1'b0;
            if (rst) begin
                rd_q <= 1'b0;
                wr_q <= 1'b0;
            end else begin
                rd_q <= m_read;
                wr_q <= m_write;
                if (m_read && !rd_q) begin
                    if (m_r_addr < DEPTH) begin
                        ram_line <= ram_mem[m_r_addr[9:0]];
                        ram_rrdy <= 1'b1;
                        ram_exc  <= 1'b0;
                    end else ram_exc <= 1'b1;
                end
                if (m_write && !wr_q) begin
                    if (m_w_addr < DEPTH) begin
                        ram_mem[m_w_addr[9:0]] <= m_w_line;
                        ram_wrdy <= 1'b1;
                        ram_exc  <= 1'b0;
                    end else ram_exc <= 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: observed=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string p);
        check({p, "_busy"},    32'(busy), 32'd0);
        check({p, "_owner"},   32'(owner), 32'd0);
        check({p, "_m_read"},  32'(m_read), 32'd0);
        check({p, "_m_write"}, 32'(m_write), 32'd0);
        check({p, "_m_raddr"}, m_r_addr, 32'd0);
        check({p, "_m_waddr"}, m_w_addr, 32'd0);
        check({p, "_m_wline"}, m_w_line, 32'd0);
        check({p, "_i_data"},  i_data, 32'd0);
        check({p, "_d_rdata"}, d_rdata, 32'd0);
        check({p, "_acks"},    32'({i_ack, d_ack}), 32'd0);
        check({p, "_excs"},    32'({i_exc, d_exc}), 32'd0);
    endtask

    // Issues one request from an idle arbiter, so the next edge is the sample edge (cycle 0).
    task automatic run_op(input string tag, input bit dport, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input bit exp_exc,
                          input int exp_cyc, input int exp_strobe);
        int n      = 0;
        int strobe = 0;
        bit got    = 1'b0;
        bit other  = 1'b0;
        if (dport) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        while (!got && n < 300) begin
            tick();
            n++;
            if (m_read || m_write) strobe++;
            got   = dport ? d_ack : i_ack;
            other = other | (dport ? i_ack : d_ack);
        end
        ack_cyc = cyc;
        check({tag, "_ack"},   32'(got), 32'd1);
        check({tag, "_cycle"}, 32'(n), 32'(exp_cyc));
        check({tag, "_data"},  dport ? d_rdata : i_data, exp_data);
        check({tag, "_exc"},   32'(dport ? d_exc : i_exc), 32'(exp_exc));
        check({tag, "_other_ack"}, 32'(other), 32'd0);
        check({tag, "_owner"}, 32'(owner), 32'(dport));
        if (exp_strobe > 0) check({tag, "_strobe_cycles"}, 32'(strobe), 32'(exp_strobe));
        if (dport) d_req = 1'b0; else i_req = 1'b0;
        tick();
        check({tag, "_idle_busy"},   32'(busy), 32'd0);
        check({tag, "_idle_strobe"}, 32'({m_read, m_write}), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 11) == 0) return 32'(DEPTH) + 32'($urandom_range(0, 500));
        return 32'($urandom_range(0, 63));
    endfunction

    task automatic new_i();
        i_req = 1'b1; i_addr = rand_addr();
    endtask

    task automatic new_d();
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr(); d_wdata = $urandom;
    endtask

    bit          exp_order [3];
    int          k, n, i_gap, d_gap, wait_n, n_acks;
    bit          ready, skip, outst, abort, rr_prio_d;
    bit          iq, dq, dwe_s, g_d, g_we, g_exc;
    logic [31:0] ia_s, da_s, dw_s, g_addr, g_wdata, exp_ird, exp_drd;

    initial begin
        for (int unsigned a = 0; a < DEPTH; a++) ref_mem[a] = init_word(a);

        tick();
        tick();
        check_reset("reset");
        rst = 1'b0;

        run_op("fetch5", 1'b0, 1'b0, 32'd5, '0, 32'hDEAD_BEEF, 1'b0, 3, 2);

        run_op("wr7", 1'b1, 1'b1, 32'd7, 32'h1234_5678, 32'h0, 1'b0, 3, 2);
        ref_mem[7] = 32'h1234_5678;
        t0 = ack_cyc;
        run_op("rd7", 1'b1, 1'b0, 32'd7, '0, 32'h1234_5678, 1'b0, 3, 2);
        check("wr_rd_ack_spacing", 32'(ack_cyc - t0), 32'd4);

        run_op("oor_rd", 1'b1, 1'b0, 32'd1024, '0, 32'h0, 1'b1, 3, 2);
        run_op("sticky_fetch0", 1'b0, 1'b0, 32'd0, '0, ref_mem[0], 1'b0, 3, 2);

        mute = 1'b1;
        run_op("timeout", 1'b0, 1'b0, 32'd9, '0, 32'h0, 1'b1, TO + 2, 0);
        mute = 1'b0;

        i_req = 1'b1; i_addr = 32'd3;
        tick();
        tick();
        check("rstmid_in_bus", 32'(busy & m_read), 32'd1);
        rst = 1'b1; i_req = 1'b0;
        tick();
        check_reset("rstmid");
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rstmid_no_ack", 32'({i_ack, d_ack}), 32'd0);
        end
        run_op("after_rst_fetch3", 1'b0, 1'b0, 32'd3, '0, ref_mem[3], 1'b0, 3, 2);

        // Contention from the reset pointer with both requests held high throughout.
        if (RR_MODE) begin
            exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
        end else begin
            exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'd5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd7;
        k = 0; n = 0;
        while (k < 3 && n < 100) begin
            tick();
            n++;
            if (i_ack || d_ack) begin
                check($sformatf("cont%0d_port_is_d", k), 32'(d_ack), 32'(exp_order[k]));
                if (d_ack) check($sformatf("cont%0d_d_rdata", k), d_rdata, ref_mem[7]);
                else       check($sformatf("cont%0d_i_data", k), i_data, ref_mem[5]);
                k++;
            end
        end
        check("cont_ack_count", 32'(k), 32'd3);
        i_req = 1'b0; d_req = 1'b0;
        tick();
        tick();

        // Randomized traffic against the transaction-level model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready = 1'b1; skip = 1'b0; outst = 1'b0; abort = 1'b0; rr_prio_d = 1'b0;
        exp_ird = '0; exp_drd = '0; wait_n = 0; n_acks = 0;
        i_gap = 0; d_gap = $urandom_range(0, 2);
        g_d = 1'b0; g_we = 1'b0; g_exc = 1'b0; g_addr = '0; g_wdata = '0;
        for (int c = 0; c < 3000 && !abort; c++) begin
            if (!i_req) begin
                if (i_gap > 0) i_gap--; else new_i();
            end
            if (!d_req) begin
                if (d_gap > 0) d_gap--; else new_d();
            end
            iq = i_req; dq = d_req; ia_s = i_addr; dwe_s = d_we; da_s = d_addr; dw_s = d_wdata;
            tick();
            if (outst) wait_n++;
            if (skip) begin
                skip  = 1'b0;
                ready = 1'b1;
            end else if (ready && (iq || dq)) begin
                g_d       = (iq && dq) ? (RR_MODE ? rr_prio_d : 1'b1) : dq;
                rr_prio_d = !g_d;
                g_we      = g_d && dwe_s;
                g_addr    = g_d ? da_s : ia_s;
                g_wdata   = dw_s;
                g_exc     = (g_addr >= DEPTH);
                if (g_we) begin
                    if (!g_exc) ref_mem[g_addr[9:0]] = g_wdata;
                end else if (g_d) exp_drd = g_exc ? '0 : ref_mem[g_addr[9:0]];
                else              exp_ird = g_exc ? '0 : ref_mem[g_addr[9:0]];
                ready = 1'b0; outst = 1'b1; wait_n = 0;
            end
            if (i_ack || d_ack) begin
                check("rnd_ack_expected", 32'(outst), 32'd1);
                check("rnd_single_ack", 32'(i_ack & d_ack), 32'd0);
                check("rnd_port_is_d", 32'(d_ack), 32'(g_d));
                check("rnd_exc", 32'(d_ack ? d_exc : i_exc), 32'(g_exc));
                check("rnd_data", d_ack ? d_rdata : i_data, d_ack ? exp_drd : exp_ird);
                n_acks++;
                outst = 1'b0;
                skip  = 1'b1;
                if (d_ack) begin
                    if ($urandom_range(0, 1) == 1) new_d();
                    else begin d_req = 1'b0; d_gap = $urandom_range(0, 3); end
                end else begin
                    if ($urandom_range(0, 1) == 1) new_i();
                    else begin i_req = 1'b0; i_gap = $urandom_range(0, 3); end
                end
            end else if (outst && wait_n > int'(TO) + 3) begin
                check("rnd_ack_within_bound", 32'({i_ack, d_ack}), 32'd1);
                abort = 1'b1;
            end
        end
        check("rnd_enough_acks", 32'(n_acks >= 300), 32'd1);
        i_req = 1'b0; d_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
